// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared types and constants for the configuration chain loader.
//   state_t : loader FSM states
//   BYTE_W  : width of one bitstream byte on the input stream
// -----------------------------------------------------------------------------
package cfg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SETUP = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cfg_phase_timer.sv
// -----------------------------------------------------------------------------
// cfg_phase_timer
// Counts the clk cycles of one prog_clk phase and flags the final cycle.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear      : restart the count at zero on the next edge
//   last       : high during the HALF_PERIOD-th cycle since the last clear
// -----------------------------------------------------------------------------
module cfg_phase_timer
  import cfg_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic last
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
// Drives the logic_element configuration shift chain from a byte stream.
// Bytes are serialised LSB-first onto prog_in; prog_clk/prog_en are generated
// here as registered, glitch-free outputs.
//
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   start              : pulse, begin a load when idle
//   abort              : terminate a load immediately (no done pulse)
//   s_data/s_valid     : bitstream byte stream in
//   s_ready            : byte accepted when s_valid && s_ready
//   prog_in/prog_clk/prog_en : serial data, shift clock, shift enable to chain
//   prog_out           : serial data returning from the chain end
//   busy               : load in progress
//   done               : one-cycle pulse on completed load
//   rb_data/rb_valid   : readback byte and one-cycle strobe
//
// Build option: CFG_READBACK_EN adds readback of the previous chain contents;
// without it rb_data/rb_valid are tied to zero.
// -----------------------------------------------------------------------------
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN   = 19,
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        next_idx;
  logic [BYTE_W-1:0] byte_q;
  logic              phase_last;
  logic              timer_clear;
  logic              accept;
  logic              do_abort;

  assign accept   = s_valid && s_ready;
  assign do_abort = abort && (state != IDLE);
  assign next_idx = bit_idx + 3'd1;

  // The phase counter only runs inside SETUP/HIGH and restarts whenever a
  // phase ends, so every SETUP and HIGH entry starts from zero.
  assign timer_clear = !((state == SETUP) || (state == HIGH)) || phase_last;

  cfg_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(timer_clear),
    .last (phase_last)
  );

  // NOTE: all state and outputs here are flops, so every assignment is
  // non-blocking; blocking would make later lines see this cycle's updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      // NOTE: byte_q is pure datapath but is reset anyway; it feeds prog_in
      // and must never leak X onto the chain.
      byte_q   <= '0;
      s_ready  <= 1'b0;
      prog_in  <= 1'b0;
      prog_clk <= 1'b0;
      prog_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_abort) begin
        // A byte handshaken in this same cycle is simply dropped: the source
        // saw it accepted, so it counts as consumed.
        state    <= IDLE;
        s_ready  <= 1'b0;
        prog_in  <= 1'b0;
        prog_clk <= 1'b0;
        prog_en  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= FETCH;
              bit_cnt  <= '0;
              s_ready  <= 1'b1;
              prog_en  <= 1'b1;
              prog_clk <= 1'b0;
              busy     <= 1'b1;
            end
          end
          FETCH: begin
            if (accept) begin
              byte_q  <= s_data;
              bit_idx <= '0;
              prog_in <= s_data[0];
              s_ready <= 1'b0;
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (phase_last) begin
              prog_clk <= 1'b1;
              state    <= HIGH;
            end
          end
          HIGH: begin
            if (phase_last) begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              prog_clk <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                // Remaining high bits of a final partial byte are discarded.
                state   <= DONE;
                prog_en <= 1'b0;
                prog_in <= 1'b0;
                done    <= 1'b1;
              end else if (bit_idx == 3'd7) begin
                state   <= FETCH;
                s_ready <= 1'b1;
              end else begin
                bit_idx <= next_idx;
                prog_in <= byte_q[next_idx];
                state   <= SETUP;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CFG_READBACK_EN
  // prog_out is sampled on the last SETUP cycle, before the rising prog_clk,
  // so the collected stream is the chain's previous contents in load order.
  logic [BYTE_W-1:0] rb_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (do_abort) begin
        rb_shift <= '0;
        rb_data  <= '0;
      end else if (state == SETUP && phase_last) begin
        rb_shift[bit_idx] <= prog_out;
      end else if (state == HIGH && phase_last &&
                   (bit_idx == 3'd7 || bit_cnt == LAST_BIT)) begin
        // Bits never written since the last strobe are still zero, which
        // gives the zero padding of a final partial byte.
        rb_data  <= rb_shift;
        rb_valid <= 1'b1;
        rb_shift <= '0;
      end
    end
  end
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_chain_loader
// Directed bench for cfg_chain_loader. A behavioural chain model shifts
// prog_in on each prog_clk rising edge (far end = bit 0 = prog_out).
// dut uses the default parameters; dut3 uses HALF_PERIOD=3, CHAIN_LEN=4.
// -----------------------------------------------------------------------------
module tb_cfg_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, s_valid;
  logic [7:0] s_data;
  logic       s_ready, prog_in, prog_clk, prog_en, prog_out, busy, done;
  logic [7:0] rb_data;
  logic       rb_valid;

  logic       start3, s_valid3;
  logic [7:0] s_data3;
  logic       s_ready3, prog_in3, prog_clk3, prog_en3, prog_out3, busy3, done3;
  logic [7:0] rb_data3;
  logic       rb_valid3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_chain_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .prog_in(prog_in), .prog_clk(prog_clk), .prog_en(prog_en),
    .prog_out(prog_out), .busy(busy), .done(done),
    .rb_data(rb_data), .rb_valid(rb_valid)
  );

  cfg_chain_loader #(.CHAIN_LEN(4), .HALF_PERIOD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
    .s_data(s_data3), .s_valid(s_valid3), .s_ready(s_ready3),
    .prog_in(prog_in3), .prog_clk(prog_clk3), .prog_en(prog_en3),
    .prog_out(prog_out3), .busy(busy3), .done(done3),
    .rb_data(rb_data3), .rb_valid(rb_valid3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- chain model and monitor for dut ----------------
  logic [18:0] chain = '0;
  assign prog_out = chain[0];
  int   edge_cnt = 0, done_cnt = 0, busy_cyc = 0;
  logic prev_clk = 1'b0;
  logic [7:0] rb_q[$];

  initial forever begin
    @(negedge clk);
    if (prog_clk && !prev_clk) begin
      chain = {prog_in, chain[18:1]};
      edge_cnt++;
    end
    prev_clk = prog_clk;
    if (done)     done_cnt++;
    if (busy)     busy_cyc++;
    if (rb_valid) rb_q.push_back(rb_data);
  end

  // ---------------- chain model and phase monitor for dut3 ----------------
  logic [3:0] chain3 = '0;
  assign prog_out3 = chain3[0];
  int   edge_cnt3 = 0, busy_cyc3 = 0, run3 = 0;
  logic prev_clk3 = 1'b0, seen_high3 = 1'b0;
  logic [5:0] hist3 = '0;
  int   high_runs[$], low_runs[$];
  int   stable_ok[$];

  initial forever begin
    @(negedge clk);
    if (prog_clk3 != prev_clk3) begin
      if (prev_clk3) begin
        high_runs.push_back(run3);
        // 3 low cycles before the rise plus 3 high cycles: prog_in constant
        stable_ok.push_back((hist3 == 6'h00 || hist3 == 6'h3F) ? 1 : 0);
      end else begin
        if (seen_high3) low_runs.push_back(run3);
        chain3 = {prog_in3, chain3[3:1]};
        edge_cnt3++;
        seen_high3 = 1'b1;
      end
      run3 = 1;
    end else begin
      run3++;
    end
    hist3     = {hist3[4:0], prog_in3};
    prev_clk3 = prog_clk3;
    if (busy3) busy_cyc3++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int stall, input bit mid_start, input string name);
    logic [7:0] bytes [3];
    int guard;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && mid_start) begin
        s_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      if (i == 1 && stall > 0) begin
        s_valid = 1'b0;
        guard = 0;
        while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
        for (int k = 0; k < stall; k++) begin
          check({name, "_stall_clk"}, 32'(prog_clk), 32'd0);
          check({name, "_stall_en"},  32'(prog_en),  32'd1);
          @(negedge clk);
        end
      end
      s_data  = bytes[i];
      s_valid = 1'b1;
      guard = 0;
      while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
      check({name, "_fetch_timeout"}, 32'(guard < 200), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    guard = 0;
    while (busy && guard < 500) begin @(negedge clk); guard++; end
    check({name, "_done_timeout"}, 32'(guard < 500), 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic run_load(input string name, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int stall, input bit mid_start,
                          input logic [18:0] exp_chain, input int exp_busy,
                          input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    int e0, d0, c0, q0;
    e0 = edge_cnt; d0 = done_cnt; c0 = busy_cyc; q0 = rb_q.size();
    do_load(b0, b1, b2, stall, mid_start, name);
    check({name, "_edges"},  32'(edge_cnt - e0), 32'd19);
    check({name, "_chain"},  32'(chain), 32'(exp_chain));
    check({name, "_done"},   32'(done_cnt - d0), 32'd1);
    check({name, "_cycles"}, 32'(busy_cyc - c0), 32'(exp_busy));
    check({name, "_prog_en"}, 32'(prog_en), 32'd0);
`ifdef CFG_READBACK_EN
    check({name, "_rb_count"}, 32'(rb_q.size() - q0), 32'd3);
    if (rb_q.size() >= q0 + 3) begin
      check({name, "_rb0"}, 32'(rb_q[q0]),     32'(r0));
      check({name, "_rb1"}, 32'(rb_q[q0 + 1]), 32'(r1));
      check({name, "_rb2"}, 32'(rb_q[q0 + 2]), 32'(r2));
    end
`else
    check({name, "_rb_count"}, 32'(rb_q.size() + (r0 & r1 & r2 & 8'h00)), 32'd0);
    check({name, "_rb_data"},  32'(rb_data), 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    start3 = 1'b0; s_valid3 = 1'b0; s_data3 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", {24'd0, s_ready, prog_in, prog_clk, prog_en, busy, done, rb_valid, 1'b0}, 32'd0);
    check("reset_rb_data", 32'(rb_data), 32'd0);

    // 1: basic load, s_valid always high; 19*2 + 3 + 1 = 42 busy cycles
    run_load("t1", 8'h50, 8'h55, 8'h05, 0, 1'b0, 19'h55550, 42, 8'h00, 8'h00, 8'h00);
    // 2: reload, readback returns the previous contents
    run_load("t2", 8'h00, 8'hF8, 8'h07, 0, 1'b0, 19'h7F800, 42, 8'h50, 8'h55, 8'h05);
    // 3: 10-cycle stall before byte 1, plus an ignored start mid-load
    run_load("t3", 8'h3C, 8'hA5, 8'h01, 10, 1'b1, 19'h1A53C, 52, 8'h00, 8'hF8, 8'h07);

    // 4: HALF_PERIOD=3 on dut3, one byte 0x0B -> bits 1,1,0,1
    @(negedge clk); start3 = 1'b1; s_data3 = 8'h0B; s_valid3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    guard = 0;
    while (!s_ready3 && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1; s_valid3 = 1'b0;
    guard = 0;
    while (busy3 && guard < 200) begin @(negedge clk); guard++; end
    check("t4_done_timeout", 32'(guard < 200), 32'd1);
    @(negedge clk); #1;
    check("t4_edges", 32'(edge_cnt3), 32'd4);
    check("t4_chain", 32'(chain3), 32'hB);
    check("t4_cycles", 32'(busy_cyc3), 32'd26);
    check("t4_high_n", 32'(high_runs.size()), 32'd4);
    check("t4_low_n", 32'(low_runs.size()), 32'd3);
    foreach (high_runs[i]) check($sformatf("t4_high%0d", i), 32'(high_runs[i]), 32'd3);
    foreach (low_runs[i])  check($sformatf("t4_low%0d", i),  32'(low_runs[i]),  32'd3);
    foreach (stable_ok[i]) check($sformatf("t4_stable%0d", i), 32'(stable_ok[i]), 32'd1);

    // 5: abort after 7 prog_clk edges
    d0 = done_cnt; guard = edge_cnt;
    @(negedge clk); s_data = 8'hFF; s_valid = 1'b1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    while (edge_cnt - guard < 7 && edge_cnt - guard >= 0 && (edge_cnt - guard) < 100) begin
      if (!busy) break;
      @(negedge clk); #1;
    end
    check("t5_reach7", 32'(edge_cnt - guard), 32'd7);
    abort = 1'b1; s_valid = 1'b0;
    @(negedge clk); #1;
    abort = 1'b0;
    check("t5_prog_en", 32'(prog_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_prog_clk", 32'(prog_clk), 32'd0);
    check("t5_s_ready", 32'(s_ready), 32'd0);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_ready", 32'(s_ready), 32'd1);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("t5_abort2_busy", 32'(busy), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // 6: asynchronous reset in the middle of a HIGH phase
    @(negedge clk); start = 1'b1; s_data = 8'hAA; s_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!prog_clk && guard < 50) begin @(negedge clk); guard++; end
    check("t6_in_high", 32'(prog_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {28'd0, prog_clk, prog_en, busy, s_ready}, 32'd0);
    s_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("t6_idle", {27'd0, prog_clk, prog_en, busy, s_ready, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
